serial_mag_compare_ctrl: RTL
============================

# serial_mag_compare_ctrl

Bit-serial magnitude comparator controller. It captures two WIDTH-bit operands on a start request and steps a single 1-bit comparator slice through them, MSB first. It stops at the first differing bit, or after bit 0 if the operands are equal. The result comes back as registered one-hot less/equal/greater flags with a done pulse, giving multi-bit compare from the existing 1-bit l/e/g datapath without a parallel comparator tree.

## Interface
Parameters:
- WIDTH, default 8: operand width in bits. Legal range is 2 to 64.

Ports:
- clk, input, 1: single clock. All state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- start, input, 1: compare request. Sampled only in IDLE.
- a, input, WIDTH: operand A. Sampled on the accepted start edge.
- b, input, WIDTH: operand B. Sampled on the accepted start edge.
- busy, output, 1: high in SCAN and DONE, low in IDLE.
- done, output, 1: high for exactly one cycle, while in DONE.
- lt, output, 1: A < B (unsigned).
- eq, output, 1: A == B.
- gt, output, 1: A > B (unsigned).

## Operation
- FSM states are IDLE, SCAN and DONE. Reset state is IDLE.
- IDLE:
  - On start=1 at an edge: load a and b into capture registers, set bit index idx = WIDTH-1, clear lt/eq/gt to 0, go to SCAN.
  - start=0: stay in IDLE.
- SCAN: present captured a[idx] and b[idx] to the slice.
  - Slice l=1: set lt=1, go to DONE.
  - Slice g=1: set gt=1, go to DONE.
  - Slice e=1 and idx==0: set eq=1, go to DONE.
  - Slice e=1 and idx>0: idx decrements by 1, stay in SCAN.
- DONE: done=1 for this one cycle, then go to IDLE unconditionally.
- start is ignored while busy=1. It is not queued, so a new request must be reasserted in IDLE.
- start held high continuously produces back-to-back compares, each separated by one IDLE cycle.
- Operands on a/b may change freely after the accepted edge; only the captured copies are used.
- Exactly one of lt/eq/gt is 1 from the DONE cycle until the next accepted start. All three are 0 after reset and during SCAN.
- Comparison is unsigned. idx is a ceil(log2(WIDTH))-bit down-counter and never wraps below 0.

## Timing
- Reset values:
  - busy=0, done=0, lt=0, eq=0, gt=0.
  - Capture registers and idx are 0.
  - State is IDLE.
- Assertion of rst_n=0 in any state, including mid-SCAN, forces all of the above immediately. The in-flight compare is aborted with no done pulse.
- Let edge 0 be the edge that accepts start, and let k be the number of bits examined (1 to WIDTH). k is the position of the first differing bit counted from the MSB, or WIDTH if the operands are equal.
  - The state enters SCAN after edge 0.
  - The result flag and the DONE state are registered at edge k.
  - done and busy are high during the cycle after edge k.
  - The state returns to IDLE at edge k+1.
- Latency from start to done is therefore k cycles: best case 1 (MSBs differ), worst case WIDTH (operands equal, or differing only in bit 0).
- The earliest next accept is edge k+2, so throughput is one compare per k+2 cycles.
- The slice is purely combinational. The decision and its registration happen in the same SCAN cycle, with no extra pipeline stage.

## Structure
- Shared package cmp_pkg:
  - state enum cmp_state_t with values IDLE, SCAN, DONE.
  - Result encoding constants CMP_LT, CMP_EQ and CMP_GT, used by both the bench and the RTL.
- One sub-module: cmp_bit_slice. It is purely combinational, with ports l, e, g, a and b: l = ~a & b, e = a ~^ b, g = a & ~b.
  - Instantiate it once, driven from the captured operands indexed by idx.
- Remaining logic lives in serial_mag_compare_ctrl:
  - FSM
  - idx counter
  - capture registers
  - result registers

## Test plan
All scenarios use WIDTH=8.
- Reset mid-op: pulse start with a=0x00, b=0x00; assert rst_n=0 during the third SCAN cycle. Required response:
  - All outputs go to 0 immediately.
  - No done pulse.
  - After release, a new start with a=0x01, b=0x00 gives gt=1.
- MSB differs: a=0x80, b=0x7F, start for one cycle. Required response:
  - done is high in the cycle after edge 1, with gt=1, lt=0, eq=0.
  - busy is low after edge 2.
- Equal operands: a=0xA5, b=0xA5. Required response:
  - done at edge 8 with eq=1.
  - busy is high for exactly 9 cycles.
- LSB differs: a=0x3C, b=0x3D. Required response: done at edge 8 with lt=1. Then change a/b during SCAN and check the result is unaffected.
- Busy-ignore and back-to-back: hold start=1 for 20 cycles with a=0x10, b=0x20. Required response:
  - lt=1 is reported at done each time.
  - Each compare accepts at its IDLE edge, at the expected spacing.
  - Starts asserted during SCAN or DONE are not accepted.
- Result hold: after a gt result, keep start=0 for 10 cycles. Required response:
  - gt stays at 1 throughout.
  - On the next accepted start, all three flags clear to 0 at the accept edge.

Source files
------------

// File: rtl/cmp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cmp_pkg
// Description : Shared state and result encodings for the serial comparator.
// Revision    : 1.0 - initial release
// ============================================================================
package cmp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } cmp_state_t;

   // Result encoding, ordered as {lt, eq, gt}
   localparam logic [2:0] CMP_LT = 3'b100;
   localparam logic [2:0] CMP_EQ = 3'b010;
   localparam logic [2:0] CMP_GT = 3'b001;

endpackage
`default_nettype wire

// File: rtl/cmp_bit_slice.sv
`default_nettype none
// ============================================================================
// Module      : cmp_bit_slice
// Description : Combinational 1-bit less/equal/greater comparator slice.
// Revision    : 1.0 - initial release
// ============================================================================
module cmp_bit_slice (
   input  logic a,
   input  logic b,
   output logic l,
   output logic e,
   output logic g
);

   assign l = ~a & b;
   assign e = a ~^ b;
   assign g = a & ~b;

endmodule
`default_nettype wire

// File: rtl/serial_mag_compare_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_mag_compare_ctrl
// Description : Bit-serial unsigned magnitude compare, MSB first, early exit.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_mag_compare_ctrl
   import cmp_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             lt,
   output logic             eq,
   output logic             gt
);

   localparam int             c_idx_w   = $clog2(WIDTH);
   localparam logic [c_idx_w-1:0] c_idx_max = c_idx_w'(WIDTH - 1);

   cmp_state_t         r_state;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [c_idx_w-1:0] r_idx;
   logic [2:0]         r_res;
   logic               r_busy;
   logic               r_done;
   logic               w_l;
   logic               w_e;
   logic               w_g;

   cmp_bit_slice u_slice (
      .a (r_a[r_idx]),
      .b (r_b[r_idx]),
      .l (w_l),
      .e (w_e),
      .g (w_g)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_idx   <= '0;
         r_res   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_idx   <= c_idx_max;
                  r_res   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= SCAN;
               end
            end
            SCAN: begin
               // Decision and result registration share this cycle
               if (w_l) begin
                  r_res   <= CMP_LT;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end else if (w_g) begin
                  r_res   <= CMP_GT;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end else if (w_e && (r_idx == '0)) begin
                  r_res   <= CMP_EQ;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end else begin
                  r_idx <= r_idx - 1'b1;
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign lt   = r_res[2];
   assign eq   = r_res[1];
   assign gt   = r_res[0];

endmodule
`default_nettype wire
